// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX stream; 1-cycle arbitration, then combinational pass-through.
// Sink backpressure reaches only the granted source; a stalled source is aborted (tuser=1 beat) and its frame remainder discarded.
module eth_tx_frame_arbiter #(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*N_PORTS-1:0]         s_axis_tdata,
    input  logic [N_PORTS-1:0]           s_axis_tvalid,
    output logic [N_PORTS-1:0]           s_axis_tready,
    input  logic [N_PORTS-1:0]           s_axis_tlast,
    input  logic [N_PORTS-1:0]           s_axis_tuser,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic [$clog2(N_PORTS)-1:0]   grant_id,
    output logic                         busy,
    output logic                         abort_pulse,
    output logic [$clog2(N_PORTS)-1:0]   abort_port
);

    localparam int PW = $clog2(N_PORTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PASS, ABORT} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      g_q, g_d;
    logic [PW-1:0]      last_q, last_d;
    logic [PW-1:0]      abort_port_q, abort_port_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_PORTS-1:0] disc_q, disc_d;
    logic               abort_pulse_q, abort_pulse_d;

    logic [N_PORTS-1:0] elig;
    logic               found;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      idx;
    logic               g_vld, g_last, g_user;
    logic [7:0]         g_data;

    assign elig   = s_axis_tvalid & ~disc_q;
    assign g_vld  = s_axis_tvalid[g_q];
    assign g_last = s_axis_tlast[g_q];
    assign g_user = s_axis_tuser[g_q];
    assign g_data = s_axis_tdata[{g_q, 3'b000} +: 8];

    // Search starts one past the last served port so every source gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = PW'((int'(last_q) + i) % N_PORTS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        disc_d        = disc_q;
        abort_port_d  = abort_port_q;
        abort_pulse_d = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        // A discarding port is never the granted one, so it can always sink.
        s_axis_tready = disc_q;

        for (int i = 0; i < N_PORTS; i++) begin
            if (disc_q[i] && s_axis_tvalid[i] && s_axis_tlast[i]) begin
                disc_d[i] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    g_d     = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                m_axis_tdata       = g_data;
                m_axis_tvalid      = g_vld;
                m_axis_tlast       = g_last;
                m_axis_tuser       = g_user;
                s_axis_tready[g_q] = m_axis_tready;
                if (g_vld) begin
                    cnt_d = '0;
                    if (m_axis_tready && g_last) begin
                        last_d  = g_q;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    abort_pulse_d = 1'b1;
                    abort_port_d  = g_q;
                    disc_d[g_q]   = 1'b1;
                    last_d        = g_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            g_q           <= '0;
            last_q        <= PW'(N_PORTS - 1);
            cnt_q         <= '0;
            disc_q        <= '0;
            abort_port_q  <= '0;
            abort_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            disc_q        <= disc_d;
            abort_port_q  <= abort_port_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

    assign grant_id    = g_q;
    assign busy        = (state_q != IDLE);
    assign abort_pulse = abort_pulse_q;
    assign abort_port  = abort_port_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed scoreboard bench for eth_tx_frame_arbiter with 4 ports and TIMEOUT=8.
// Source queues feed the DUT; expected output beats are queued at load time and popped on each master handshake.
module tb_eth_tx_frame_arbiter;

    localparam int NP = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [7:0] gap;
    } sbeat_t;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       last;
        logic       user;
    } mbeat_t;

    logic            clk;
    logic            rst_n;
    logic [8*NP-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tready;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tuser;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [1:0]      grant_id;
    logic            busy;
    logic            abort_pulse;
    logic [1:0]      abort_port;

    sbeat_t        srcq [NP][$];
    mbeat_t        sbq [$];
    int            hs_cyc_q [$];
    logic [NP-1:0] hs;
    logic [NP-1:0] hold;
    sbeat_t        tmp_b;
    mbeat_t        exp_b;
    int            cyc = 0;
    int            n_abort = 0;
    int            rdy_mode = 1;
    int            n_cmp = 0;
    int            n_mis = 0;
    logic          saw_conc = 1'b0;

    eth_tx_frame_arbiter #(.N_PORTS(NP), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_id      (grant_id),
        .busy          (busy),
        .abort_pulse   (abort_pulse),
        .abort_port    (abort_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void load(input int p, input int n, input logic [7:0] base, input int n_exp,
                                 input int gap_at, input logic [7:0] gap, input bit ulast);
        sbeat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 8'(i);
            b.last = (i == n - 1);
            b.user = ulast && (i == n - 1);
            b.gap  = (i == gap_at) ? gap : 8'd0;
            srcq[p].push_back(b);
            if (i < n_exp) sbq.push_back({2'(p), b.data, b.last, b.user});
        end
    endfunction

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int k = 0;
        while ((sbq.size() != 0 || !srcs_empty()) && k < bound) begin
            sample();
            k++;
        end
        check(tag, 32'(k < bound), 32'd1);
        repeat (2) sample();
    endtask

    // Source/sink driver and output monitor: handshakes sampled at negedge, inputs updated 1ns after posedge.
    initial begin
        hs            = '0;
        hold          = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            hs = s_axis_tvalid & s_axis_tready;
            if (abort_pulse === 1'b1) n_abort++;
            if (hs[2] && busy && grant_id == 2'd3 && m_axis_tvalid) saw_conc = 1'b1;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                hs_cyc_q.push_back(cyc);
                check("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_b = sbq.pop_front();
                    check("out_beat", 32'({grant_id, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(exp_b));
                end
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && srcq[p].size() != 0) void'(srcq[p].pop_front());
                hold[p] = 1'b0;
                if (srcq[p].size() != 0 && srcq[p][0].gap != 8'd0) begin
                    tmp_b      = srcq[p][0];
                    tmp_b.gap  = tmp_b.gap - 8'd1;
                    srcq[p][0] = tmp_b;
                    hold[p]    = 1'b1;
                end
                if (srcq[p].size() != 0 && !hold[p]) begin
                    s_axis_tvalid[p]       = 1'b1;
                    s_axis_tdata[8*p +: 8] = srcq[p][0].data;
                    s_axis_tlast[p]        = srcq[p][0].last;
                    s_axis_tuser[p]        = srcq[p][0].user;
                end else begin
                    s_axis_tvalid[p]       = 1'b0;
                    s_axis_tdata[8*p +: 8] = 8'h00;
                    s_axis_tlast[p]        = 1'b0;
                    s_axis_tuser[p]        = 1'b0;
                end
            end
            m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    initial begin
        int k;
        int nb;
        int idle;
        rst_n = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_abort_pulse", 32'(abort_pulse), 32'd0);
        check("rst_abort_port", 32'(abort_port), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) sample();

        // Single 64-byte frame on port 0.
        load(0, 64, 8'h00, 64, -1, 8'd0, 1'b0);
        k = 0;
        do begin sample(); k++; end while (!s_axis_tvalid[0] && k < 10);
        check("t1_no_out_in_req_cycle", 32'({busy, m_axis_tvalid}), 32'd0);
        sample();
        check("t1_first_beat", 32'({m_axis_tvalid, m_axis_tdata}), 32'h100);
        nb = int'(busy);
        repeat (80) begin sample(); nb += int'(busy); end
        check("t1_busy_cycles", 32'(nb), 32'd64);
        wait_drain("t1_drain", 20);

        // All ports with back-to-back 10-byte frames; rotation resumes after port 0.
        for (int f = 0; f < 2; f++)
            for (int j = 0; j < NP; j++)
                load((j + 1) % NP, 10, 8'(((j + 1) % NP) * 64 + f * 16), 10, -1, 8'd0, ((j + 1) % NP) == 3);
        k = 0;
        do begin sample(); k++; end while (!m_axis_tvalid && k < 10);
        idle = 0;
        k = 0;
        while (sbq.size() != 0 && k < 200) begin
            sample();
            k++;
            if (!m_axis_tvalid) idle++;
        end
        check("t2_idle_between_frames", 32'(idle), 32'd7);
        wait_drain("t2_drain", 50);

        // Port 1 under random and long sink backpressure with ports 2/0 waiting.
        rdy_mode = 2;
        load(1, 20, 8'h10, 20, -1, 8'd0, 1'b0);
        load(2, 5, 8'h30, 5, -1, 8'd0, 1'b0);
        load(0, 5, 8'h50, 5, -1, 8'd0, 1'b0);
        repeat (6) sample();
        rdy_mode = 0;
        repeat (20) sample();
        check("t3_held_under_stall", 32'({busy, grant_id}), 32'h5);
        rdy_mode = 2;
        wait_drain("t3_drain", 300);
        rdy_mode = 1;
        check("t3_no_abort", 32'(n_abort), 32'd0);

        // Source gap of TIMEOUT-1 idle cycles: the beat arriving on the last cycle wins.
        hs_cyc_q.delete();
        load(0, 4, 8'hA0, 4, 2, 8'd7, 1'b0);
        wait_drain("t3b_drain", 50);
        check("t3b_gap_cycles", 32'((hs_cyc_q.size() >= 3) ? hs_cyc_q[2] - hs_cyc_q[1] : -1), 32'd8);
        check("t3b_no_abort", 32'(n_abort), 32'd0);

        // Port 2 stalls after 5 beats: abort, port 3 next, remainder discarded alongside port 3.
        hs_cyc_q.delete();
        saw_conc = 1'b0;
        load(2, 11, 8'h20, 5, 5, 8'd20, 1'b0);
        sbq.push_back({2'd2, 8'h00, 1'b1, 1'b1});
        load(3, 20, 8'h40, 20, -1, 8'd0, 1'b0);
        load(2, 3, 8'h60, 3, -1, 8'd0, 1'b0);
        wait_drain("t4_drain", 200);
        check("t4_abort_delay", 32'((hs_cyc_q.size() >= 6) ? hs_cyc_q[5] - hs_cyc_q[4] : -1), 32'd9);
        check("t4_abort_pulses", 32'(n_abort), 32'd1);
        check("t4_abort_port", 32'(abort_port), 32'd2);
        check("t4_discard_concurrent", 32'(saw_conc), 32'd1);

        // Reset in the middle of a port 1 frame.
        load(1, 30, 8'h80, 30, -1, 8'd0, 1'b0);
        k = 0;
        do begin sample(); k++; end while (!(m_axis_tvalid && grant_id == 2'd1) && k < 20);
        repeat (5) sample();
        step();
        rst_n = 1'b0;
        #1;
        check("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_s_tready", 32'(s_axis_tready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_grant_id", 32'(grant_id), 32'd0);
        check("t6_abort_port", 32'(abort_port), 32'd0);
        for (int p = 0; p < NP; p++) srcq[p].delete();
        sbq.delete();
        repeat (3) step();
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++) load(p, 3, 8'(8'hC0 + p * 8), 3, -1, 8'd0, 1'b0);
        wait_drain("t6_drain", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
